as_top_mem_jtag: RTL and testbench

- Top-level RV64I system wrapper (instantiated as as_top_mem). Contains a JTAG TAP with an I-Mem scan data register, a 256x32 instruction memory, a 256x64 data memory, and a GPIO output port with a chip-select strobe.
- Instantiates the existing codebase core as_rv64i_core: single-cycle, combinational instruction fetch, combinational data read, synchronous store.
- The host loads the program over JTAG while rst_i holds the core in reset, then releases rst_i.

---
 rtl/as_top_mem_jtag.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_as_top_mem_jtag.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/as_top_mem_jtag.sv
// RV64I system top: JTAG TAP with an I-Mem scan register, 256x32 I-Mem, 256x64 D-Mem and a GPIO port.
// The TAP runs entirely in clk_i; TCK/TMS/TDI are synchronised and TCK rising edges become TAP steps.

module as_rv64i_core (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    output logic [63:0] pc_o,
    output logic [63:0] dAddr_o,
    output logic [63:0] dWdata_o,
    output logic [1:0]  dSize_o,
    output logic        dWe_o,
    input  logic [63:0] dRdata_i
);
    logic [63:0] pc_q, pc_d;
    logic [63:0] regs_q [32];
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2, shamtW;
    logic [2:0]  f3;
    logic [63:0] rs1v, rs2v, opB, immI, immS, immB, immU, immJ;
    logic [63:0] aluRes, loadVal, rdVal;
    logic [31:0] a32, b32, aluW;
    logic [5:0]  shamt;
    logic        isSub, take, rdWe;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign f3     = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign rs1v   = (rs1 == 5'd0) ? 64'd0 : regs_q[rs1];
    assign rs2v   = (rs2 == 5'd0) ? 64'd0 : regs_q[rs2];
    assign immI   = {{52{instr_i[31]}}, instr_i[31:20]};
    assign immS   = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign immB   = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign immU   = {{32{instr_i[31]}}, instr_i[31:12], 12'd0};
    assign immJ   = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign pc_o   = pc_q;

    // Register-register forms take rs2; everything else uses the I-immediate
    always_comb begin
        opB    = (opcode == 7'b0110011 || opcode == 7'b0111011) ? rs2v : immI;
        isSub  = (opcode == 7'b0110011 || opcode == 7'b0111011) && instr_i[30];
        shamt  = opB[5:0];
        shamtW = opB[4:0];
        a32    = rs1v[31:0];
        b32    = opB[31:0];
        aluRes = rs1v + opB;
        aluW   = a32 + b32;
        case (f3)
            3'd0: aluRes = isSub ? rs1v - opB : rs1v + opB;
            3'd1: aluRes = rs1v << shamt;
            3'd2: aluRes = {63'd0, $signed(rs1v) < $signed(opB)};
            3'd3: aluRes = {63'd0, rs1v < opB};
            3'd4: aluRes = rs1v ^ opB;
            3'd5: aluRes = instr_i[30] ? $signed(rs1v) >>> shamt : rs1v >> shamt;
            3'd6: aluRes = rs1v | opB;
            3'd7: aluRes = rs1v & opB;
            default: ;
        endcase
        case (f3)
            3'd0: aluW = isSub ? a32 - b32 : a32 + b32;
            3'd1: aluW = a32 << shamtW;
            3'd5: aluW = instr_i[30] ? $signed(a32) >>> shamtW : a32 >> shamtW;
            default: ;
        endcase
        case (f3)
            3'd0: loadVal = {{56{dRdata_i[7]}}, dRdata_i[7:0]};
            3'd1: loadVal = {{48{dRdata_i[15]}}, dRdata_i[15:0]};
            3'd2: loadVal = {{32{dRdata_i[31]}}, dRdata_i[31:0]};
            3'd4: loadVal = {56'd0, dRdata_i[7:0]};
            3'd5: loadVal = {48'd0, dRdata_i[15:0]};
            3'd6: loadVal = {32'd0, dRdata_i[31:0]};
            default: loadVal = dRdata_i;
        endcase
        case (f3)
            3'd0: take = (rs1v == rs2v);
            3'd1: take = (rs1v != rs2v);
            3'd4: take = ($signed(rs1v) < $signed(rs2v));
            3'd5: take = ($signed(rs1v) >= $signed(rs2v));
            3'd6: take = (rs1v < rs2v);
            3'd7: take = (rs1v >= rs2v);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        pc_d     = pc_q + 64'd4;
        rdWe     = 1'b0;
        rdVal    = aluRes;
        dWe_o    = 1'b0;
        dAddr_o  = rs1v + immI;
        dWdata_o = rs2v;
        dSize_o  = f3[1:0];
        case (opcode)
            7'b0110111: begin rdWe = 1'b1; rdVal = immU; end
            7'b0010111: begin rdWe = 1'b1; rdVal = pc_q + immU; end
            7'b1101111: begin rdWe = 1'b1; rdVal = pc_q + 64'd4; pc_d = pc_q + immJ; end
            7'b1100111: begin rdWe = 1'b1; rdVal = pc_q + 64'd4; pc_d = (rs1v + immI) & ~64'd1; end
            7'b1100011: if (take) pc_d = pc_q + immB;
            7'b0000011: begin rdWe = 1'b1; rdVal = loadVal; end
            7'b0100011: begin dWe_o = ~rst_i; dAddr_o = rs1v + immS; end
            7'b0010011, 7'b0110011: rdWe = 1'b1;
            7'b0011011, 7'b0111011: begin rdWe = 1'b1; rdVal = {{32{aluW[31]}}, aluW}; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pc_q <= 64'd0;
        else       pc_q <= pc_d;
    end

    always_ff @(posedge clk_i) begin
        if (rdWe && !rst_i && rd != 5'd0) regs_q[rd] <= rdVal;
    end
endmodule

module as_top_mem_jtag #(
    parameter int          IMEM_ADDR_WIDTH = 10,
    parameter int          INSTR_WIDTH     = 32,
    parameter int          IM_SCAN_LENGTH  = 43,
    parameter int          IR_LENGTH       = 8,
    parameter logic [7:0]  IMDR_OPCODE     = 8'h80,
    parameter int          NR_GPIOS        = 32,
    parameter logic [63:0] GPIO_ADDR       = 64'h4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tck_i,
    input  logic                trst_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o
);
    typedef enum logic [3:0] {
        TLR, IDLE, SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tapState_e;

    tapState_e                 tapState_q, tapState_d;
    logic [1:0]                tckSync_q, tmsSync_q, tdiSync_q;
    logic                      tckPrev_q, tapStep, tms, tdi, imdrSel, imWrite;
    logic [IR_LENGTH-1:0]      irSr_q, ir_q;
    logic [IM_SCAN_LENGTH-1:0] imdr_q;
    logic                      bypass_q;
    logic [INSTR_WIDTH-1:0]    imem_q [256];
    logic [63:0]               dmem_q [256];
    logic [NR_GPIOS-1:0]       gpio_q;
    logic                      cs_q;

    logic [63:0] pc, dAddr, dWdata, dRdata, laneData, rawWord;
    logic [1:0]  dSize;
    logic        dWe, isGpio, gpioWrite;
    logic [2:0]  dOff;
    logic [7:0]  dIdx, sizeMask, dBe;
    logic        unusedBits;

    assign tapStep = tckSync_q[1] & ~tckPrev_q;
    assign tms     = tmsSync_q[1];
    assign tdi     = tdiSync_q[1];
    assign imdrSel = (ir_q == IMDR_OPCODE);
    assign imWrite = tapStep && (tapState_q == UPD_DR) && imdrSel && imdr_q[0];

    always_ff @(posedge clk_i or posedge trst_i) begin
        if (trst_i) begin
            tckSync_q  <= 2'b00;
            tmsSync_q  <= 2'b00;
            tdiSync_q  <= 2'b00;
            tckPrev_q  <= 1'b0;
            tapState_q <= TLR;
        end else begin
            tckSync_q  <= {tckSync_q[0], tck_i};
            tmsSync_q  <= {tmsSync_q[0], tms_i};
            tdiSync_q  <= {tdiSync_q[0], tdi_i};
            tckPrev_q  <= tckSync_q[1];
            tapState_q <= tapState_d;
        end
    end

    always_comb begin
        tapState_d = tapState_q;
        if (tapStep) begin
            case (tapState_q)
                TLR:      tapState_d = tms ? TLR      : IDLE;
                IDLE:     tapState_d = tms ? SEL_DR   : IDLE;
                SEL_DR:   tapState_d = tms ? SEL_IR   : CAP_DR;
                CAP_DR:   tapState_d = tms ? EX1_DR   : SHIFT_DR;
                SHIFT_DR: tapState_d = tms ? EX1_DR   : SHIFT_DR;
                EX1_DR:   tapState_d = tms ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: tapState_d = tms ? EX2_DR   : PAUSE_DR;
                EX2_DR:   tapState_d = tms ? UPD_DR   : SHIFT_DR;
                UPD_DR:   tapState_d = tms ? SEL_DR   : IDLE;
                SEL_IR:   tapState_d = tms ? TLR      : CAP_IR;
                CAP_IR:   tapState_d = tms ? EX1_IR   : SHIFT_IR;
                SHIFT_IR: tapState_d = tms ? EX1_IR   : SHIFT_IR;
                EX1_IR:   tapState_d = tms ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: tapState_d = tms ? EX2_IR   : PAUSE_IR;
                EX2_IR:   tapState_d = tms ? UPD_IR   : SHIFT_IR;
                UPD_IR:   tapState_d = tms ? SEL_DR   : IDLE;
                default:  tapState_d = TLR;
            endcase
        end
    end

    // Capture/shift/update act on the step taken while sitting in the corresponding state
    always_ff @(posedge clk_i or posedge trst_i) begin
        if (trst_i) begin
            irSr_q   <= 8'h01;
            ir_q     <= 8'h01;
            imdr_q   <= '0;
            bypass_q <= 1'b0;
        end else begin
            if (tapState_q == TLR) ir_q <= 8'h01;
            if (tapStep) begin
                case (tapState_q)
                    CAP_IR:   irSr_q <= 8'h01;
                    SHIFT_IR: irSr_q <= {irSr_q[IR_LENGTH-2:0], tdi};
                    UPD_IR:   ir_q   <= irSr_q;
                    CAP_DR:   if (imdrSel) imdr_q <= '0; else bypass_q <= 1'b0;
                    SHIFT_DR: if (imdrSel) imdr_q <= {imdr_q[IM_SCAN_LENGTH-2:0], tdi};
                              else         bypass_q <= tdi;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tdo_o = 1'b0;
        if (tapState_q == SHIFT_IR)      tdo_o = irSr_q[IR_LENGTH-1];
        else if (tapState_q == SHIFT_DR) tdo_o = imdrSel ? imdr_q[IM_SCAN_LENGTH-1] : bypass_q;
    end

    // Scan layout is {addr[9:0], data[31:0], we}; the word index is addr[9:2]
    always_ff @(posedge clk_i) begin
        if (imWrite) imem_q[imdr_q[42:35]] <= imdr_q[32:1];
    end

    as_rv64i_core u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .instr_i  (imem_q[pc[IMEM_ADDR_WIDTH-1:2]]),
        .pc_o     (pc),
        .dAddr_o  (dAddr),
        .dWdata_o (dWdata),
        .dSize_o  (dSize),
        .dWe_o    (dWe),
        .dRdata_i (dRdata)
    );

    assign unusedBits = ^{pc[63:IMEM_ADDR_WIDTH], pc[1:0], imdr_q[34:33]};
    assign isGpio     = (dAddr == GPIO_ADDR);
    assign gpioWrite  = dWe && isGpio;
    assign dOff       = dAddr[2:0];
    assign dIdx       = dAddr[10:3];
    assign rawWord    = dmem_q[dIdx];
    assign laneData   = dWdata << {dOff, 3'b000};
    assign dRdata     = isGpio ? {{(64-NR_GPIOS){1'b0}}, gpio_q} : (rawWord >> {dOff, 3'b000});

    always_comb begin
        case (dSize)
            2'd0:    sizeMask = 8'h01;
            2'd1:    sizeMask = 8'h03;
            2'd2:    sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase
        dBe = sizeMask << dOff;
    end

    always_ff @(posedge clk_i) begin
        if (dWe && !isGpio) begin
            for (int b = 0; b < 8; b++) begin
                if (dBe[b]) dmem_q[dIdx][b*8 +: 8] <= laneData[b*8 +: 8];
            end
        end
    end

    // cs_o rises together with the new GPIO value, one cycle per store
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gpio_q <= '0;
            cs_q   <= 1'b0;
        end else begin
            cs_q <= gpioWrite;
            if (gpioWrite) gpio_q <= dWdata[NR_GPIOS-1:0];
        end
    end

    assign gpio_io = gpio_q;
    assign cs_o    = cs_q;
endmodule

// File: tb/tb_as_top_mem_jtag.sv
// Directed bench for as_top_mem_jtag: loads programs over the synchronised JTAG port and
// watches the GPIO strobe and value, with expected values written out by hand.

module tb_as_top_mem_jtag;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tck = 1'b0;
    logic        trst = 1'b1;
    logic        tms = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic        cs;
    wire  [31:0] gpio;

    int checks = 0;
    int failures = 0;

    as_top_mem_jtag dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .tck_i   (tck),
        .trst_i  (trst),
        .tms_i   (tms),
        .tdi_i   (tdi),
        .tdo_o   (tdo),
        .gpio_io (gpio),
        .cs_o    (cs)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One TCK period of 8 clk cycles; TDO is sampled just before TCK rises
    task automatic applyStimulus(input logic tmsV, input logic tdiV, output logic tdoV);
        tck = 1'b0;
        tms = tmsV;
        tdi = tdiV;
        repeat (4) @(negedge clk);
        tdoV = tdo;
        tck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic jtagIr(input logic [7:0] v, output logic [7:0] captured);
        logic t;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(i == 0, v[i], t);
            captured[i] = t;
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
    endtask

    task automatic jtagDr(input logic [42:0] v);
        logic t;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 42; i >= 0; i--) applyStimulus(i == 0, v[i], t);
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
    endtask

    // Releases reset and watches 40 cycles for the GPIO store
    task automatic runProgram(input string tag);
        int pulses = 0;
        int firstCycle = 0;
        logic [31:0] seen = 32'd0;
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (cs) begin
                pulses++;
                if (pulses == 1) begin
                    firstCycle = c;
                    seen = gpio;
                end
            end
        end
        checkOutput({tag, "_pulses"}, 64'(pulses), 64'd1);
        checkOutput({tag, "_latency"}, 64'(firstCycle), 64'd3);
        checkOutput({tag, "_gpio_at_cs"}, 64'(seen), 64'd29);
        checkOutput({tag, "_gpio_hold"}, 64'(gpio), 64'd29);
    endtask

    logic        t;
    logic [7:0]  irCap;
    logic [42:0] firstHalf, secondHalf;
    logic [4:0]  bypassSeen;
    logic [3:0]  bypassPat;

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_tdo", 64'(tdo), 64'd0);
        checkOutput("reset_gpio", 64'(gpio), 64'd0);
        checkOutput("reset_cs", 64'(cs), 64'd0);
        trst = 1'b0;
        repeat (3) @(negedge clk);

        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b1, 1'b0, t);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);

        jtagIr(8'h80, irCap);
        checkOutput("ir_capture", 64'(irCap), 64'h01);

        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < 86; i++) begin
            applyStimulus(i == 85, i < 43, t);
            if (i < 43) firstHalf[42-i] = t;
            else        secondHalf[85-i] = t;
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        checkOutput("imdr_capture_zeros", 64'(firstHalf), 64'd0);
        checkOutput("imdr_ones_out", 64'(secondHalf), 64'h7FF_FFFF_FFFF);

        for (int i = 0; i < 5; i++) jtagDr({10'(i * 4), 32'h0, 1'b1});
        for (int i = 0; i < 5; i++) checkOutput($sformatf("erase_w%0d", i), 64'(dut.imem_q[i]), 64'd0);

        jtagDr({10'h000, 32'h01D00093, 1'b1});
        jtagDr({10'h004, 32'h00400113, 1'b1});
        jtagDr({10'h008, 32'h00113023, 1'b1});
        jtagDr({10'h00C, 32'h0000006F, 1'b1});
        checkOutput("load_w2", 64'(dut.imem_q[2]), 64'h00113023);
        runProgram("run1");

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_gpio", 64'(gpio), 64'd0);
        checkOutput("midrst_cs", 64'(cs), 64'd0);
        @(negedge clk);
        runProgram("rerun");

        @(negedge clk);
        rst = 1'b1;
        jtagDr({10'h000, 32'h4AAAAA88, 1'b0});
        checkOutput("we0_w0", 64'(dut.imem_q[0]), 64'h01D00093);
        runProgram("we0run");

        jtagIr(8'hFF, irCap);
        bypassPat = 4'b1011;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 4, (i < 4) ? bypassPat[3-i] : 1'b0, t);
            bypassSeen[4-i] = t;
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        checkOutput("bypass_delay", 64'(bypassSeen), 64'b01011);
        checkOutput("bypass_w0", 64'(dut.imem_q[0]), 64'h01D00093);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
